adder_pipe: RTL

Parametrised, pipelined add/subtract unit with valid/ready flow control, carry in/out, unsigned overflow detection and optional saturation. It is the next-generation replacement for the fixed 2-bit registered adder. It generalises operand width and pipeline depth and adds subtract, saturate and backpressure. It sits between an operand producer and a result consumer on one clock domain.

---
 rtl/adder_pipe_if.sv | 30 +++
 rtl/adder_pipe.sv | 123 ++++++++++++
 2 files changed

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
// Signals: in_valid/in_ready with a, b, cin, sub, sat (operand beat);
//          out_valid/out_ready with f, cout, ovf (result beat).
// master: producer/consumer side; slave: the adder itself.
interface adder_pipe_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, f, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, f, cout, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract unit with valid/ready flow control
// Ports: m_clock  - clock, rising edge
//        p_reset  - synchronous active-high reset
//        io       - adder_pipe_if.slave: operand beat (in_valid/in_ready, a, b, cin, sub, sat)
//                   and result beat (out_valid/out_ready, f, cout, ovf)
// Parameters: W operand width, SEG stages (1 <= SEG <= W, W % SEG == 0).
module adder_pipe #(
    parameter int W   = 8,
    parameter int SEG = 2
) (
    input  logic        m_clock,
    input  logic        p_reset,
    adder_pipe_if.slave io
);
    localparam int SL = W / SEG;

    assign io.in_ready = g_stage[0].rdy && !p_reset;

    for (genvar k = 0; k < SEG; k++) begin : g_stage
        // Stage k only carries the operand bits it and later stages still need,
        // plus the result bits already produced by earlier stages.
        localparam int AW = W - k * SL;
        localparam int LW = k * SL;

        logic              vin;
        logic              c_in;
        logic              sub_in;
        logic              sat_in;
        logic [AW-1:0]     a_in;
        logic [AW-1:0]     bp_in;
        logic [SL:0]       slice;
        logic [LW+SL-1:0]  s_d;
        logic              v_q;
        logic              rdy;
        logic              rdy_nxt;

        if (k == 0) begin : g_src
            // Subtract is a + ~b + ~borrow, so the inversion happens once on entry.
            assign vin    = io.in_valid;
            assign a_in   = io.a;
            assign bp_in  = io.sub ? ~io.b : io.b;
            assign c_in   = io.sub ? ~io.cin : io.cin;
            assign sub_in = io.sub;
            assign sat_in = io.sat;
            assign s_d    = slice[SL-1:0];
        end else begin : g_src
            assign vin    = g_stage[k-1].v_q;
            assign a_in   = g_stage[k-1].g_reg.a_q;
            assign bp_in  = g_stage[k-1].g_reg.bp_q;
            assign c_in   = g_stage[k-1].g_reg.c_q;
            assign sub_in = g_stage[k-1].g_reg.sub_q;
            assign sat_in = g_stage[k-1].g_reg.sat_q;
            assign s_d    = {slice[SL-1:0], g_stage[k-1].g_reg.s_q};
        end

        assign slice = {1'b0, a_in[SL-1:0]} + {1'b0, bp_in[SL-1:0]} + {{SL{1'b0}}, c_in};

        // A stage may load when empty or when its contents leave this cycle;
        // the chain is combinational so bubbles collapse in one cycle.
        assign rdy = !v_q || rdy_nxt;

        if (k < SEG - 1) begin : g_reg
            logic [AW-SL-1:0] a_q;
            logic [AW-SL-1:0] bp_q;
            logic [LW+SL-1:0] s_q;
            logic             c_q;
            logic             sub_q;
            logic             sat_q;

            assign rdy_nxt = g_stage[k+1].rdy;

            always_ff @(posedge m_clock) begin
                if (p_reset) begin
                    v_q <= 1'b0;
                end else if (rdy) begin
                    v_q <= vin;
                    if (vin) begin
                        a_q   <= a_in[AW-1:SL];
                        bp_q  <= bp_in[AW-1:SL];
                        s_q   <= s_d;
                        c_q   <= slice[SL];
                        sub_q <= sub_in;
                        sat_q <= sat_in;
                    end
                end
            end
        end else begin : g_out
            logic         ovf_d;
            logic [W-1:0] f_d;
            logic [W-1:0] f_q;
            logic         cout_q;
            logic         ovf_q;

            assign rdy_nxt = io.out_ready;

            // Final carry of a subtract is the inverted borrow, so underflow is ~carry.
            assign ovf_d = sub_in ? ~slice[SL] : slice[SL];
            // Clamp to all-ones on add overflow, zero on subtract underflow.
            assign f_d   = (sat_in && ovf_d) ? {W{~sub_in}} : s_d;

            always_ff @(posedge m_clock) begin
                if (p_reset) begin
                    v_q    <= 1'b0;
                    f_q    <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (rdy) begin
                    v_q <= vin;
                    if (vin) begin
                        f_q    <= f_d;
                        cout_q <= slice[SL];
                        ovf_q  <= ovf_d;
                    end
                end
            end

            assign io.out_valid = v_q;
            assign io.f         = f_q;
            assign io.cout      = cout_q;
            assign io.ovf       = ovf_q;
        end
    end
endmodule
